// File: rtl/ifetch_queue_pkg.sv
// ifetch_pkg: shared defaults, PC step and the queue entry type {pc, instr} for the fetch front end
package ifetch_pkg;
  localparam int DEF_DEPTH = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int DEF_IM_AW = 10;
  localparam logic [31:0] PC_STEP = 32'd4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: fetch bundle (redirect in, imem req/addr/rdata, out valid/ready/pc/instr, queue_count); master = fetch unit, slave = environment
interface ifetch_queue_if import ifetch_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IM_AW = DEF_IM_AW
);
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic im_req;
  logic [IM_AW-1:0] im_addr;
  logic [31:0] im_rdata;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [$clog2(DEPTH):0] queue_count;
  modport master (
    input redirect_valid, redirect_pc, im_rdata, out_ready,
    output im_req, im_addr, out_valid, out_pc, out_instr, queue_count
  );
  modport slave (
    output redirect_valid, redirect_pc, im_rdata, out_ready,
    input im_req, im_addr, out_valid, out_pc, out_instr, queue_count
  );
endinterface

// File: rtl/ifetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry sync FIFO of fetch_entry_t; ports clk, rst, flush, push/push_data, pop, head (zero when empty), count
module fetch_fifo import ifetch_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  fetch_entry_t push_data,
  input  logic pop,
  output fetch_entry_t head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_pop;
  assign do_pop = pop && count != '0;
  assign head = count != '0 ? mem[rd_ptr] : '0;
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: MIPS fetch PC, one-deep pending imem read and credit logic feeding fetch_fifo; ports clk, rst, bus (ifetch_queue_if.master)
module ifetch_queue import ifetch_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int IM_AW = DEF_IM_AW
) (
  input logic clk,
  input logic rst,
  ifetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [31:0] fetch_pc, pend_pc;
  logic pend_valid;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  fetch_entry_t head, rsp;
  assign occ = {1'b0, count} + (CW+1)'(pend_valid);
  assign bus.im_req = !rst && !bus.redirect_valid && occ < (CW+1)'(DEPTH);
  assign bus.im_addr = fetch_pc[IM_AW+1:2];
  assign rsp = '{pc: pend_pc, instr: bus.im_rdata};
  assign bus.out_valid = count != '0;
  assign bus.out_pc = head.pc;
  assign bus.out_instr = head.instr;
  assign bus.queue_count = count;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(bus.redirect_valid),
    .push(pend_valid && !bus.redirect_valid),
    .push_data(rsp),
    .pop(bus.out_valid && bus.out_ready),
    .head(head),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      pend_valid <= 1'b0;
    end else begin
      pend_valid <= bus.im_req;
      if (bus.im_req) begin
        pend_pc <= fetch_pc;
        fetch_pc <= fetch_pc + PC_STEP;
      end
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: scoreboard bench for ifetch_queue with a one-cycle-latency instruction memory model
module tb_ifetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ifetch_queue_if #(.DEPTH(4), .IM_AW(10)) bus();
  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .IM_AW(10)) dut (.clk(clk), .rst(rst), .bus(bus));
  always @(posedge clk) bus.im_rdata <= 32'h1000_0000 + {22'd0, bus.im_addr};
  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb [$];
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_ppc = 32'h0;
  logic m_pend = 1'b0;
  int m_cnt = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic cycle();
    logic exp_req, push, pop;
    logic [63:0] hd;
    #2;
    exp_req = !rst && !bus.redirect_valid && (m_cnt + int'(m_pend)) < 4;
    chk("im_req", 64'(bus.im_req), 64'(exp_req));
    if (exp_req) chk("im_addr", 64'(bus.im_addr), 64'(m_pc[11:2]));
    chk("count", 64'(bus.queue_count), 64'(m_cnt));
    chk("valid", 64'(bus.out_valid), 64'(m_cnt != 0));
    hd = (m_cnt != 0 && sb.size() != 0) ? sb[0] : 64'd0;
    chk("head", {bus.out_pc, bus.out_instr}, hd);
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h0;
      m_pend = 1'b0;
      m_cnt = 0;
      sb.delete();
    end else if (bus.redirect_valid) begin
      m_pc = {bus.redirect_pc[31:2], 2'b00};
      m_pend = 1'b0;
      m_cnt = 0;
      sb.delete();
    end else begin
      pop = m_cnt > 0 && bus.out_ready;
      push = m_pend;
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back({m_ppc, 32'h1000_0000 + {22'd0, m_ppc[11:2]}});
      m_cnt = m_cnt + int'(push) - int'(pop);
      m_pend = exp_req;
      if (exp_req) begin
        m_ppc = m_pc;
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    run(2);
    rst = 1'b0;
    run(12);
    chk("steady_cnt", 64'(bus.queue_count), 64'd1);
    bus.out_ready = 1'b0;
    run(10);
    chk("sat_cnt", 64'(bus.queue_count), 64'd4);
    #1 chk("sat_req", 64'(bus.im_req), 64'd0);
    bus.out_ready = 1'b1;
    run(8);
    bus.out_ready = 1'b0;
    run(1);
    chk("pre_rd_cnt", 64'(bus.queue_count), 64'd3);
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0203;
    cycle();
    bus.redirect_valid = 1'b0;
    chk("rd_cnt", 64'(bus.queue_count), 64'd0);
    chk("rd_valid", 64'(bus.out_valid), 64'd0);
    chk("rd_addr", 64'(bus.im_addr), 64'h080);
    run(2);
    chk("rd_pc", 64'(bus.out_pc), 64'h200);
    run(4);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    cycle();
    bus.redirect_pc = 32'h80;
    cycle();
    bus.redirect_pc = 32'hC0;
    cycle();
    bus.redirect_valid = 1'b0;
    run(2);
    chk("tr_pc", 64'(bus.out_pc), 64'hC0);
    run(4);
    bus.out_ready = 1'b0;
    run(2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_cnt", 64'(bus.queue_count), 64'd0);
    chk("rst_head", {bus.out_pc, bus.out_instr}, 64'd0);
    chk("rst_addr", 64'(bus.im_addr), 64'd0);
    bus.out_ready = 1'b1;
    run(6);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    cycle();
    bus.redirect_valid = 1'b0;
    chk("wr_a0", 64'(bus.im_addr), 64'h3FF);
    cycle();
    chk("wr_a1", 64'(bus.im_addr), 64'h000);
    cycle();
    chk("wr_pc0", 64'(bus.out_pc), 64'hFFFF_FFFC);
    cycle();
    chk("wr_pc1", 64'(bus.out_pc), 64'h0);
    run(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction-fetch front end of the five-stage MIPS pipeline. It owns the fetch PC and issues word reads to the 4 KB instruction memory, which has one-cycle read latency. Returned instructions are buffered with their PCs in a small prefetch queue that feeds the IF/ID pipeline register through a valid/ready handshake. A redirect (taken branch, jump, jr) flushes the queue, discards any read in flight, and restarts fetch at the target.

## Interface
Parameters:
- `DEPTH`, 4 — queue entries; power of two, minimum 2.
- `RESET_PC`, 32'h0000_0000 — fetch address after reset.
- `IM_AW`, 10 — instruction-memory word-address width.

Ports:
- `clk` input 1 — the only clock; all state updates on the rising edge.
- `rst` input 1 — reset, synchronous, active-high.
- `redirect_valid` input 1 — redirect fetch this cycle.
- `redirect_pc` input 32 — redirect target; bits [1:0] are ignored and forced to 0.
- `im_req` output 1 — read request to instruction memory this cycle.
- `im_addr` output IM_AW — word address, equal to `fetch_pc[IM_AW+1:2]`.
- `im_rdata` input 32 — read data, valid the cycle after `im_req`.
- `out_valid` output 1 — queue head is valid.
- `out_ready` input 1 — IF/ID accepts the head; the IF/ID stall signal drives this low.
- `out_pc` output 32 — PC of the head entry; 0 when the queue is empty.
- `out_instr` output 32 — instruction of the head entry; 0 when the queue is empty.
- `queue_count` output $clog2(DEPTH)+1 — current occupancy.

## Operation
State:
- `fetch_pc`
- `pend_valid`, `pend_pc` — one outstanding read.
- FIFO storage, read and write pointers, count.

Request:
- `im_req = !rst && !redirect_valid && (count + pend_valid) < DEPTH`.
- A pop in the same cycle earns no credit; this conservative rule keeps the queue from overflowing.
- On request: `pend_valid<=1`, `pend_pc<=fetch_pc`, `fetch_pc<=fetch_pc+4`.
- If no request is made, `pend_valid<=0`.
- The PC wraps modulo 2^32. `im_addr` wraps modulo 4 KB.

Response:
- If `pend_valid`, push {`pend_pc`, `im_rdata`} into the FIFO this cycle.

Pop:
- When `out_valid && out_ready`, the head advances.
- A push and a pop in the same cycle leave the count unchanged.
- A push into an empty queue is visible no earlier than the next cycle; there is no bypass.

Redirect (priority over everything except `rst`):
- Count and pointers clear.
- `pend_valid<=0`; the response arriving this cycle is dropped.
- `fetch_pc<={redirect_pc[31:2],2'b00}`.
- No request is made this cycle.
- A concurrent pop counts as consumed by the downstream side; the queue still empties.

Reset:
- `fetch_pc=RESET_PC`; `pend_valid=0`; count and pointers 0.
- Outputs: `im_req=0`, `out_valid=0`, `out_pc=0`, `out_instr=0`, `queue_count=0`.
- Reset applied mid-operation behaves identically, including a discarded in-flight read.

## Timing
- Request in cycle N → data enters the queue at the end of N+1 → `out_valid` in N+2. Minimum fetch-to-issue latency is 2 cycles.
- First cycle with `rst` low: `im_req=1` for `RESET_PC`. The first `out_valid` comes 2 cycles later.
- Redirect in cycle R: first request for the target in R+1, `out_valid` in R+3. `out_valid` is 0 in R+1 and R+2.
- With `out_ready` held at 1, throughput is one instruction per cycle (count=1 and one read pending in steady state).
- With `out_ready=0`, the queue fills to DEPTH, then `im_req` drops; nothing is overwritten or lost.
- `out_*` and `queue_count` come from registers and FIFO storage only; there is no combinational path from `out_ready`.
- `im_req` depends combinationally on `redirect_valid`.

## Structure
- Package `ifetch_pkg`:
  - `DEPTH`, `RESET_PC` and `IM_AW` defaults.
  - `fetch_entry_t` = {pc[31:0], instr[31:0]}.
  - Constant `PC_STEP`=4.
- Sub-module `fetch_fifo`: synchronous DEPTH-entry FIFO of `fetch_entry_t` with `flush`, push/pop, count, and a head-zero-when-empty output.
- The top holds the PC, pending-read tracking and credit logic only.

## Test plan
- Reset release, `out_ready=1`, memory word i = 32'h1000_0000+i → `out_pc` 0,4,8,… on consecutive cycles from cycle 2 with matching `out_instr`; `queue_count` ≤2.
- Hold `out_ready=0` for 10 cycles → `queue_count` saturates at 4 and `im_req` goes low. Release → PCs 0,4,8,12,16,… arrive with no gap or duplicate.
- Full queue plus read pending; assert redirect to 32'h0000_0203 → next cycle `queue_count`=0 and `out_valid`=0. The first request uses `im_addr`=10'h080; `out_pc`=32'h0000_0200 three cycles after the redirect; the stale response is never output.
- Redirect asserted for 3 consecutive cycles (targets 0x40, 0x80, 0xC0) → only 0xC0 and its successors are ever output.
- `rst` asserted with the queue half full and a read pending → all outputs 0 next cycle; after release, fetch restarts at `RESET_PC`.
- Redirect to 32'hFFFF_FFFC → `out_pc` FFFF_FFFC then 0000_0000; `im_addr` 10'h3FF then 10'h000.
